// File: rtl/uart_tx_arbiter_pkg.sv
// Shared UART arbiter types: FSM state encoding and data width.
package uart_tx_arbiter_pkg;

  localparam int unsigned UART_DATA_W = 8;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_START  = 2'd1,
    ARB_ACTIVE = 2'd2,
    ARB_DONE   = 2'd3
  } arb_state_e;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid requester after rr_ptr_i, with wrap.
module uart_tx_arbiter_rr_pick #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_valid_i,
  input  logic [ID_W-1:0]  rr_ptr_i,
  output logic [ID_W-1:0]  winner_o,
  output logic             any_valid_o
);

  logic [ID_W-1:0] idx;

  // Scan rr_ptr+1 .. rr_ptr+N_REQ (mod N_REQ); the first set bit wins.
  always_comb begin
    winner_o    = '0;
    any_valid_o = 1'b0;
    idx         = '0;
    for (int unsigned off = 1; off <= N_REQ; off++) begin
      idx = ID_W'((32'(rr_ptr_i) + off) % N_REQ);
      if (!any_valid_o && req_valid_i[idx]) begin
        winner_o    = idx;
        any_valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among N_REQ byte requesters.
// Optional frame timeout enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned ID_W        = $clog2(N_REQ),
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_REQ-1:0]             req_valid,
  input  logic [UART_DATA_W*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]             req_ack,
  output logic                         tx_start,
  output logic [UART_DATA_W-1:0]       tx_data,
  input  logic                         tx_active,
  input  logic                         tx_done,
  output logic [ID_W-1:0]              grant_id,
  output logic                         busy,
  output logic                         timeout_err
);

  // Reject configurations outside the supported range at elaboration.
  if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYC < 2) begin : g_bad_cfg
    $error("uart_tx_arbiter: unsupported N_REQ/TIMEOUT_CYC");
  end

  arb_state_e             state_q, state_d;
  logic [N_REQ-1:0]       req_ack_q, req_ack_d;
  logic                   tx_start_q, tx_start_d;
  logic [UART_DATA_W-1:0] tx_data_q, tx_data_d;
  logic [ID_W-1:0]        grant_id_q, grant_id_d;
  logic                   busy_q, busy_d;
  logic [ID_W-1:0]        rr_ptr_q, rr_ptr_d;

  logic [ID_W-1:0]        winner;
  logic                   any_valid;
  logic [UART_DATA_W-1:0] req_bytes [N_REQ];

`ifdef UART_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_err_q, timeout_err_d;
  logic             frame_expired;

  assign frame_expired = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
  assign timeout_err   = timeout_err_q;
`else
  assign timeout_err   = 1'b0;
`endif

  // Split the flat request bus into per-requester bytes.
  for (genvar g = 0; g < N_REQ; g++) begin : g_bytes
    assign req_bytes[g] = req_data[g*UART_DATA_W +: UART_DATA_W];
  end

  uart_tx_arbiter_rr_pick #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_pick (
    .req_valid_i (req_valid),
    .rr_ptr_i    (rr_ptr_q),
    .winner_o    (winner),
    .any_valid_o (any_valid)
  );

  // Next-state and next-output logic for the grant/frame FSM.
  always_comb begin
    state_d    = state_q;
    req_ack_d  = '0;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    grant_id_d = grant_id_q;
    busy_d     = busy_q;
    rr_ptr_d   = rr_ptr_q;
`ifdef UART_ARB_TIMEOUT_EN
    cnt_d         = cnt_q;
    timeout_err_d = timeout_err_q;
`endif
    case (state_q)
      ARB_IDLE: begin
        if (any_valid) begin
          tx_data_d  = req_bytes[winner];
          grant_id_d = winner;
          req_ack_d  = N_REQ'(1) << winner;
          tx_start_d = 1'b1;
          busy_d     = 1'b1;
          state_d    = ARB_START;
`ifdef UART_ARB_TIMEOUT_EN
          cnt_d      = '0;
`endif
        end
      end
      ARB_START: begin
`ifdef UART_ARB_TIMEOUT_EN
        cnt_d = cnt_q + CNT_W'(1);
`endif
        if (tx_done) begin
          state_d = ARB_DONE;
`ifdef UART_ARB_TIMEOUT_EN
        end else if (frame_expired) begin
          timeout_err_d = 1'b1;
          state_d       = ARB_DONE;
`endif
        end else if (tx_active) begin
          state_d = ARB_ACTIVE;
        end
      end
      ARB_ACTIVE: begin
`ifdef UART_ARB_TIMEOUT_EN
        cnt_d = cnt_q + CNT_W'(1);
`endif
        if (tx_done) begin
          state_d = ARB_DONE;
`ifdef UART_ARB_TIMEOUT_EN
        end else if (frame_expired) begin
          timeout_err_d = 1'b1;
          state_d       = ARB_DONE;
`endif
        end
      end
      ARB_DONE: begin
        rr_ptr_d = grant_id_q;
        busy_d   = 1'b0;
        state_d  = ARB_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any frame in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ARB_IDLE;
      req_ack_q     <= '0;
      tx_start_q    <= 1'b0;
      tx_data_q     <= '0;
      grant_id_q    <= '0;
      busy_q        <= 1'b0;
      rr_ptr_q      <= ID_W'(N_REQ - 1);
`ifdef UART_ARB_TIMEOUT_EN
      cnt_q         <= '0;
      timeout_err_q <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      req_ack_q     <= req_ack_d;
      tx_start_q    <= tx_start_d;
      tx_data_q     <= tx_data_d;
      grant_id_q    <= grant_id_d;
      busy_q        <= busy_d;
      rr_ptr_q      <= rr_ptr_d;
`ifdef UART_ARB_TIMEOUT_EN
      cnt_q         <= cnt_d;
      timeout_err_q <= timeout_err_d;
`endif
    end
  end

  assign req_ack  = req_ack_q;
  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;
  assign grant_id = grant_id_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter (N_REQ=4); exercises the timeout path when
// UART_ARB_TIMEOUT_EN is defined (TIMEOUT_CYC=16).
module tb_uart_tx_arbiter;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int unsigned TB_TO = 16;
`else
  localparam int unsigned TB_TO = 4096;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ack;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_active;
  logic        tx_done;
  logic [1:0]  grant_id;
  logic        busy;
  logic        timeout_err;

  int    n_assert = 0;
  int    n_fail   = 0;
  string step     = "init";

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .N_REQ       (4),
    .ID_W        (2),
    .TIMEOUT_CYC (TB_TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ack     (req_ack),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx_active   (tx_active),
    .tx_done     (tx_done),
    .grant_id    (grant_id),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s/%s: observed %0h expected %0h", step, tag, obs, exp);
    end
  endtask

  // Next edge must start a frame for requester id with the given byte.
  task automatic expect_grant(input int id, input logic [7:0] data);
    @(posedge clk); #1;
    check("tx_start", 32'(tx_start), 32'd1);
    check("req_ack", 32'(req_ack), 32'd1 << id);
    check("grant_id", 32'(grant_id), 32'(id));
    check("tx_data", 32'(tx_data), 32'(data));
    check("busy", 32'(busy), 32'd1);
  endtask

  // Run a normal frame from START to IDLE; late_valid is applied mid-frame.
  task automatic finish_frame(input logic [3:0] late_valid);
    tx_active = 1'b1;
    @(posedge clk); #1;
    check("act_start", 32'(tx_start), 32'd0);
    check("act_ack", 32'(req_ack), 32'd0);
    check("act_busy", 32'(busy), 32'd1);
    req_valid = late_valid;
    @(posedge clk); #1;
    check("act2_ack", 32'(req_ack), 32'd0);
    tx_done   = 1'b1;
    tx_active = 1'b0;
    @(posedge clk); #1;
    check("done_busy", 32'(busy), 32'd1);
    tx_done = 1'b0;
    @(posedge clk); #1;
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_start", 32'(tx_start), 32'd0);
  endtask

  initial begin
    rst       = 1'b0;
    req_valid = 4'b0000;
    req_data  = 32'h0;
    tx_active = 1'b0;
    tx_done   = 1'b0;

    // Reset values
    step = "reset";
    repeat (2) @(posedge clk);
    #1;
    check("busy", 32'(busy), 32'd0);
    check("tx_start", 32'(tx_start), 32'd0);
    check("req_ack", 32'(req_ack), 32'd0);
    check("grant_id", 32'(grant_id), 32'd0);
    check("tx_data", 32'(tx_data), 32'd0);
    check("timeout_err", 32'(timeout_err), 32'd0);

    // Reset mid-ACTIVE clears everything immediately
    step = "rst_mid";
    rst       = 1'b1;
    req_valid = 4'b1111;
    req_data  = 32'hA3A2A1A0;
    expect_grant(0, 8'hA0);
    tx_active = 1'b1;
    @(posedge clk); #1;
    check("active_busy", 32'(busy), 32'd1);
    rst = 1'b0;
    #1;
    check("busy", 32'(busy), 32'd0);
    check("tx_data", 32'(tx_data), 32'd0);
    check("tx_start", 32'(tx_start), 32'd0);
    check("req_ack", 32'(req_ack), 32'd0);
    rst       = 1'b1;
    tx_active = 1'b0;

    // All valid: strict rotation A0,A1,A2,A3,A0
    step = "rotate";
    expect_grant(0, 8'hA0);
    finish_frame(4'b1111);
    expect_grant(1, 8'hA1);
    finish_frame(4'b1111);
    expect_grant(2, 8'hA2);
    finish_frame(4'b1111);
    expect_grant(3, 8'hA3);
    finish_frame(4'b1111);
    expect_grant(0, 8'hA0);
    finish_frame(4'b0100);

    // Single requester 2 served every frame
    step = "single";
    req_valid = 4'b0100;
    req_data  = 32'hA35CA1A0;
    for (int i = 0; i < 3; i++) begin
      expect_grant(2, 8'h5C);
      finish_frame(4'b0100);
    end

    // Requester 1 withdraws before being served; requester 3 wins next
    step = "withdraw";
    req_valid = 4'b0001;
    req_data  = 32'h335CA111;
    expect_grant(0, 8'h11);
    req_valid = 4'b0010;
    finish_frame(4'b1000);
    expect_grant(3, 8'h33);
    req_valid = 4'b0000;
    finish_frame(4'b0000);

    // tx_done in START without tx_active
    step = "done_in_start";
    req_valid = 4'b0001;
    expect_grant(0, 8'h11);
    req_valid = 4'b0000;
    tx_done   = 1'b1;
    @(posedge clk); #1;
    check("done_busy", 32'(busy), 32'd1);
    check("done_ack", 32'(req_ack), 32'd0);
    tx_done = 1'b0;
    @(posedge clk); #1;
    check("idle_busy", 32'(busy), 32'd0);
    tx_done   = 1'b1;
    tx_active = 1'b1;
    @(posedge clk); #1;
    check("idle_ignore_busy", 32'(busy), 32'd0);
    check("idle_ignore_start", 32'(tx_start), 32'd0);
    tx_done   = 1'b0;
    tx_active = 1'b0;

    // Stalled frame: timeout (if built) or indefinite wait
    step = "stall";
    req_valid = 4'b0100;
    expect_grant(2, 8'h5C);
    req_valid = 4'b0000;
    tx_active = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    check("pre_to_busy", 32'(busy), 32'd1);
    check("pre_to_err", 32'(timeout_err), 32'd0);
`ifdef UART_ARB_TIMEOUT_EN
    @(posedge clk); #1;
    check("to_err", 32'(timeout_err), 32'd1);
    check("to_busy", 32'(busy), 32'd1);
    @(posedge clk); #1;
    check("to_idle_busy", 32'(busy), 32'd0);
    check("to_sticky", 32'(timeout_err), 32'd1);
    tx_active = 1'b0;
`else
    repeat (25) @(posedge clk);
    #1;
    check("wait_busy", 32'(busy), 32'd1);
    check("wait_err", 32'(timeout_err), 32'd0);
    tx_done   = 1'b1;
    tx_active = 1'b0;
    @(posedge clk); #1;
    tx_done = 1'b0;
    @(posedge clk); #1;
    check("release_busy", 32'(busy), 32'd0);
`endif
    req_valid = 4'b0110;
    req_data  = 32'h335C2211;
    expect_grant(1, 8'h22);
    req_valid = 4'b0000;
    finish_frame(4'b0000);
`ifdef UART_ARB_TIMEOUT_EN
    check("final_err", 32'(timeout_err), 32'd1);
`else
    check("final_err", 32'(timeout_err), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
